// File: rtl/branch_resolve_pkg.sv
// Shared definitions for the branch resolution unit and the ALU it consumes.
//  - br_kind encodings presented by the execute stage
//  - funct3 branch condition codes
//  - alu_status bit positions (common with the ALU flag producer)
//  - FSM state typedef for branch_resolve
package branch_resolve_pkg;

    localparam logic [1:0] KIND_BRANCH = 2'd0;
    localparam logic [1:0] KIND_JAL    = 2'd1;
    localparam logic [1:0] KIND_JALR   = 2'd2;
    localparam logic [1:0] KIND_RSVD   = 2'd3;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam int unsigned STAT_EQ  = 0;
    localparam int unsigned STAT_LT  = 1;
    localparam int unsigned STAT_LTU = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_FLUSH    = 2'd2
    } br_state_e;

endpackage

// File: rtl/br_cond_eval.sv
// Combinational branch condition evaluation.
// Ports:
//   funct3     in  3  branch condition code (BRANCH only)
//   kind       in  2  control-flow kind
//   alu_status in  3  ALU compare flags {ltu, lt, eq}
//   taken      out 1  instruction redirects control flow
//   illegal    out 1  reserved funct3 or reserved kind
module br_cond_eval
    import branch_resolve_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [1:0] kind,
    input  logic [2:0] alu_status,
    output logic       taken,
    output logic       illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (kind)
            KIND_BRANCH: begin
                case (funct3)
                    F3_BEQ:  taken =  alu_status[STAT_EQ];
                    F3_BNE:  taken = ~alu_status[STAT_EQ];
                    F3_BLT:  taken =  alu_status[STAT_LT];
                    F3_BGE:  taken = ~alu_status[STAT_LT];
                    F3_BLTU: taken =  alu_status[STAT_LTU];
                    F3_BGEU: taken = ~alu_status[STAT_LTU];
                    default: illegal = 1'b1;
                endcase
            end
            KIND_JAL,
            KIND_JALR: taken = 1'b1;
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch/jump resolution against the fetch prediction.
// Issues a held redirect on mispredict, then a fixed-length flush, and keeps
// saturating performance counters.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   br_valid/br_ready               instruction handshake (ready only in IDLE)
//   br_kind, br_funct3              instruction kind and branch condition
//   br_pred_taken                   fetch-stage prediction
//   br_pc, br_imm, br_base          PC, sign-extended immediate, rs1 (JALR)
//   alu_status                      ALU compare flags {ltu, lt, eq}
//   link_addr                       pc+4 of last accepted JAL/JALR
//   redirect_valid/target/ready     redirect handshake to fetch
//   flush                           squash younger stages
//   exc_misalign, exc_illegal       one-cycle exception pulses
//   cnt_branches, cnt_mispredict    saturating perf counters
//
// state       | meaning
// ST_IDLE     | accepting instructions
// ST_REDIRECT | redirect_valid held until fetch accepts
// ST_FLUSH    | flush asserted for FLUSH_CYCLES cycles
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [1:0]       br_kind,
    input  logic [2:0]       br_funct3,
    input  logic             br_pred_taken,
    input  logic [XLEN-1:0]  br_pc,
    input  logic [XLEN-1:0]  br_imm,
    input  logic [XLEN-1:0]  br_base,
    input  logic [2:0]       alu_status,
    output logic [XLEN-1:0]  link_addr,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_target,
    input  logic             redirect_ready,
    output logic             flush,
    output logic             exc_misalign,
    output logic             exc_illegal,
    output logic [CNT_W-1:0] cnt_branches,
    output logic [CNT_W-1:0] cnt_mispredict
);

    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);

    br_state_e       state_q;
    br_state_e       state_d;
    logic [FW-1:0]   flush_cnt_q;

    logic            accept;
    logic            taken;
    logic            illegal;
    logic            is_jump;
    logic            misalign;
    logic            mispredict;
    logic            handshake;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] taken_target;

    br_cond_eval u_cond (
        .funct3     (br_funct3),
        .kind       (br_kind),
        .alu_status (alu_status),
        .taken      (taken),
        .illegal    (illegal)
    );

    assign accept       = br_valid & br_ready;
    assign is_jump      = (br_kind == KIND_JAL) | (br_kind == KIND_JALR);
    assign seq_pc       = br_pc + XLEN'(4);
    assign taken_target = (br_kind == KIND_JALR) ? ((br_base + br_imm) & ~XLEN'(1))
                                                 : (br_pc + br_imm);
    // A misaligned taken target raises an exception instead of a redirect.
    assign misalign     = taken & taken_target[1];
    assign mispredict   = ~illegal & ~misalign & (taken != br_pred_taken);
    assign handshake    = (state_q == ST_REDIRECT) & redirect_ready;

    always_comb begin
        state_d        = state_q;
        br_ready       = 1'b0;
        redirect_valid = 1'b0;
        flush          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                br_ready = 1'b1;
                if (accept && mispredict) begin
                    state_d = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                redirect_valid = 1'b1;
                if (redirect_ready) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                flush = 1'b1;
                if (flush_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            flush_cnt_q     <= '0;
            redirect_target <= '0;
            link_addr       <= '0;
            exc_misalign    <= 1'b0;
            exc_illegal     <= 1'b0;
            cnt_branches    <= '0;
            cnt_mispredict  <= '0;
        end else begin
            state_q      <= state_d;
            exc_misalign <= accept & misalign;
            exc_illegal  <= accept & illegal;

            if (accept && mispredict) begin
                redirect_target <= taken ? taken_target : seq_pc;
            end
            if (accept && is_jump) begin
                link_addr <= seq_pc;
            end

            // Down-counter: the flush state ends on the cycle it reads zero.
            if (handshake) begin
                flush_cnt_q <= FLUSH_LOAD;
            end else if ((state_q == ST_FLUSH) && (flush_cnt_q != '0)) begin
                flush_cnt_q <= flush_cnt_q - 1'b1;
            end

            if (accept && !(&cnt_branches)) begin
                cnt_branches <= cnt_branches + 1'b1;
            end
            if (accept && mispredict && !(&cnt_mispredict)) begin
                cnt_mispredict <= cnt_mispredict + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios followed by
// randomized instructions, checked against a behavioural model. A second
// instance with 4-bit counters shares the stimulus to observe saturation.
module tb_branch_resolve;

    localparam int XLEN = 32;
    localparam int FC   = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            br_valid = 1'b0;
    logic [1:0]      br_kind = '0;
    logic [2:0]      br_funct3 = '0;
    logic            br_pred_taken = 1'b0;
    logic [XLEN-1:0] br_pc = '0, br_imm = '0, br_base = '0;
    logic [2:0]      alu_status = '0;
    logic            redirect_ready = 1'b0;

    logic            br_ready, redirect_valid, flush, exc_misalign, exc_illegal;
    logic [XLEN-1:0] link_addr, redirect_target;
    logic [15:0]     cnt_branches, cnt_mispredict;

    logic            br_ready_s, redirect_valid_s, flush_s, exc_misalign_s, exc_illegal_s;
    logic [XLEN-1:0] link_addr_s, redirect_target_s;
    logic [3:0]      cnt_branches_s, cnt_mispredict_s;

    always #5 clk = ~clk;

    branch_resolve #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(br_ready),
        .br_kind(br_kind), .br_funct3(br_funct3), .br_pred_taken(br_pred_taken),
        .br_pc(br_pc), .br_imm(br_imm), .br_base(br_base), .alu_status(alu_status),
        .link_addr(link_addr), .redirect_valid(redirect_valid),
        .redirect_target(redirect_target), .redirect_ready(redirect_ready),
        .flush(flush), .exc_misalign(exc_misalign), .exc_illegal(exc_illegal),
        .cnt_branches(cnt_branches), .cnt_mispredict(cnt_mispredict)
    );

    branch_resolve #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .br_valid(br_valid), .br_ready(br_ready_s),
        .br_kind(br_kind), .br_funct3(br_funct3), .br_pred_taken(br_pred_taken),
        .br_pc(br_pc), .br_imm(br_imm), .br_base(br_base), .alu_status(alu_status),
        .link_addr(link_addr_s), .redirect_valid(redirect_valid_s),
        .redirect_target(redirect_target_s), .redirect_ready(redirect_ready),
        .flush(flush_s), .exc_misalign(exc_misalign_s), .exc_illegal(exc_illegal_s),
        .cnt_branches(cnt_branches_s), .cnt_mispredict(cnt_mispredict_s)
    );

    int vectors = 0;
    int miscompares = 0;
    int exp_br = 0;
    int exp_mp = 0;
    logic [XLEN-1:0] exp_link = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sat(input int c, input int w);
        int mx;
        mx = (1 << w) - 1;
        return 32'((c > mx) ? mx : c);
    endfunction

    task automatic check_counters();
        chk("cnt_branches",     32'(cnt_branches),     sat(exp_br, 16));
        chk("cnt_mispredict",   32'(cnt_mispredict),   sat(exp_mp, 16));
        chk("cnt_branches_w4",  32'(cnt_branches_s),   sat(exp_br, 4));
        chk("cnt_mispredict_w4",32'(cnt_mispredict_s), sat(exp_mp, 4));
    endtask

    task automatic drive_junk();
        br_valid      = 1'($urandom);
        br_kind       = 2'($urandom);
        br_funct3     = 3'($urandom);
        br_pred_taken = 1'($urandom);
        br_pc         = $urandom;
        br_imm        = $urandom;
        br_base       = $urandom;
        alu_status    = 3'($urandom);
    endtask

    // Called at a negedge with the unit idle. Applies one instruction whose
    // compare flags come from operands a/b, then walks any redirect/flush.
    task automatic issue(input logic [1:0] kind, input logic [2:0] f3, input logic pred,
                         input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] base,
                         input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit rst_mid);
        logic ill, tk, mis, mp;
        logic [31:0] tt, tgt;

        ill = (kind == 2'd3) || (kind == 2'd0 && (f3 == 3'b010 || f3 == 3'b011));
        tk  = 1'b0;
        if (kind == 2'd1 || kind == 2'd2) tk = 1'b1;
        else if (kind == 2'd0 && !ill) begin
            case (f3)
                3'b000:  tk = (a == b);
                3'b001:  tk = (a != b);
                3'b100:  tk = ($signed(a) <  $signed(b));
                3'b101:  tk = ($signed(a) >= $signed(b));
                3'b110:  tk = (a <  b);
                default: tk = (a >= b);
            endcase
        end
        tt  = (kind == 2'd2) ? ((base + imm) & 32'hFFFF_FFFE) : (pc + imm);
        mis = tk && tt[1];
        mp  = !ill && !mis && (tk != pred);
        tgt = tk ? tt : pc + 32'd4;

        chk("br_ready_idle", 32'(br_ready), 32'd1);
        br_valid = 1'b1; br_kind = kind; br_funct3 = f3; br_pred_taken = pred;
        br_pc = pc; br_imm = imm; br_base = base;
        alu_status = {a < b, $signed(a) < $signed(b), a == b};
        @(posedge clk); #1;
        br_valid = 1'b0;
        exp_br++;
        if (kind == 2'd1 || kind == 2'd2) exp_link = pc + 32'd4;
        if (mp) exp_mp++;

        @(negedge clk);
        chk("exc_misalign",   32'(exc_misalign),   32'(mis));
        chk("exc_illegal",    32'(exc_illegal),    32'(ill));
        chk("redirect_valid", 32'(redirect_valid), 32'(mp));
        chk("br_ready_after", 32'(br_ready),       32'(!mp));
        chk("link_addr",      link_addr,           exp_link);
        check_counters();

        if (!mp) begin
            @(negedge clk);
            chk("exc_misalign_pulse", 32'(exc_misalign), 32'd0);
            chk("exc_illegal_pulse",  32'(exc_illegal),  32'd0);
            return;
        end

        chk("redirect_target", redirect_target, tgt);
        chk("flush_in_redirect", 32'(flush), 32'd0);

        if (rst_mid) begin
            redirect_ready = 1'b1;
            rst_n = 1'b0;
            @(posedge clk); #1;
            rst_n = 1'b1;
            exp_br = 0; exp_mp = 0; exp_link = '0;
            @(negedge clk);
            chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
            chk("rst_br_ready",       32'(br_ready),       32'd1);
            chk("rst_flush",          32'(flush),          32'd0);
            chk("rst_target",         redirect_target,     32'd0);
            chk("rst_link",           link_addr,           32'd0);
            check_counters();
            redirect_ready = 1'b0;
            @(negedge clk);
            chk("rst_no_flush_after", 32'(flush), 32'd0);
            return;
        end

        for (int i = 0; i < hold; i++) begin
            drive_junk();
            redirect_ready = 1'b0;
            @(negedge clk);
            chk("redirect_hold_valid",  32'(redirect_valid), 32'd1);
            chk("redirect_hold_target", redirect_target,     tgt);
            chk("redirect_hold_ready",  32'(br_ready),       32'd0);
            chk("redirect_hold_flush",  32'(flush),          32'd0);
        end
        redirect_ready = 1'b1;
        drive_junk();
        @(posedge clk); #1;
        redirect_ready = 1'b0;
        @(negedge clk);
        for (int i = 0; i < FC; i++) begin
            chk("flush_high",       32'(flush),          32'd1);
            chk("flush_rv_low",     32'(redirect_valid), 32'd0);
            chk("flush_ready_low",  32'(br_ready),       32'd0);
            check_counters();
            drive_junk();
            @(negedge clk);
        end
        br_valid = 1'b0;
        chk("flush_done",       32'(flush),    32'd0);
        chk("flush_done_ready", 32'(br_ready), 32'd1);
        check_counters();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  k;
        logic [31:0] a, b, imm;

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_br_ready",       32'(br_ready),       32'd1);
        chk("reset_redirect_valid", 32'(redirect_valid), 32'd0);
        chk("reset_flush",          32'(flush),          32'd0);
        chk("reset_exc",            32'({exc_misalign, exc_illegal}), 32'd0);
        chk("reset_target",         redirect_target,     32'd0);
        chk("reset_link",           link_addr,           32'd0);
        check_counters();
        rst_n = 1'b1;
        @(negedge clk);

        // BEQ taken, predicted not taken, fetch stalls 3 cycles
        issue(2'd0, 3'b000, 1'b0, 32'h100, 32'h20, 32'h0, 32'd5, 32'd5, 3, 1'b0);
        // BLTU not taken, predicted not taken
        issue(2'd0, 3'b110, 1'b0, 32'h180, 32'h40, 32'h0, 32'd7, 32'd3, 0, 1'b0);
        // JALR misaligned target, then aligned JALR
        issue(2'd2, 3'b000, 1'b0, 32'h200, 32'd2, 32'h1001, 32'd0, 32'd0, 1, 1'b0);
        issue(2'd2, 3'b000, 1'b0, 32'h300, 32'd5, 32'h1000, 32'd0, 32'd0, 1, 1'b0);
        // BGE taken predicted taken; BNE not taken predicted taken
        issue(2'd0, 3'b101, 1'b1, 32'h400, 32'h40, 32'h0, 32'd9, 32'd2, 0, 1'b0);
        issue(2'd0, 3'b001, 1'b1, 32'h500, 32'h40, 32'h0, 32'd4, 32'd4, 0, 1'b0);
        // Illegal funct3, reserved kind, wrap-around target
        issue(2'd0, 3'b010, 1'b1, 32'h600, 32'h8, 32'h0, 32'd1, 32'd1, 0, 1'b0);
        issue(2'd3, 3'b000, 1'b0, 32'h604, 32'h8, 32'h0, 32'd1, 32'd1, 0, 1'b0);
        issue(2'd1, 3'b000, 1'b0, 32'hFFFF_FFF0, 32'h20, 32'h0, 32'd0, 32'd0, 0, 1'b0);
        // Reset while redirect pending
        issue(2'd0, 3'b000, 1'b1, 32'h700, 32'h10, 32'h0, 32'd1, 32'd2, 0, 1'b1);

        // 20 mispredicted JALs saturate the 4-bit counters
        for (int i = 0; i < 20; i++) begin
            issue(2'd1, 3'b000, 1'b0, $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
                  32'h0, 32'd0, 32'd0, $urandom_range(0, 2), 1'b0);
        end

        for (int i = 0; i < 80; i++) begin
            k = ($urandom_range(0, 9) < 6) ? 2'd0 : 2'($urandom_range(1, 3));
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            imm = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            issue(k, 3'($urandom), 1'($urandom), $urandom & 32'hFFFF_FFFC, imm, $urandom,
                  a, b, $urandom_range(0, 3), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
